// File: rtl/seq_serializer_if.sv
// Handshake and serial-stream bundle for seq_serializer.
// The master side offers parallel words and consumes serial bits.
// The slave side is the serializer itself.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic [15:0]      word_cnt;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output ser_en,
    input  ser_out,
    input  ser_valid,
    input  busy,
    input  word_cnt
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  ser_en,
    output ser_out,
    output ser_valid,
    output busy,
    output word_cnt
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer.
// Accepts WIDTH-bit words over a valid/ready handshake and shifts them
// out one bit per ser_en cycle.  A word offered while another is
// shifting is parked in the holding register, so consecutive words
// stream without a gap in ser_valid.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  seq_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_reg,     state_next;
  logic [WIDTH-1:0] shreg_reg,     shreg_next;
  logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
  logic [WIDTH-1:0] hold_reg,      hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [15:0]      word_cnt_reg,  word_cnt_next;

  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;
  logic             xfer;
  logic             last_bit;

  // Shift direction and output tap depend only on the bit-order parameter.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg_reg[WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
      assign out_bit       = shreg_reg[0];
    end
  endgenerate

  // The holding register is the only thing that can refuse a word.
  assign xfer     = bus.in_valid && !hold_full_reg;
  assign last_bit = (state_reg == ST_SHIFT) && bus.ser_en && (bit_cnt_reg == CNT_ONE);

  assign bus.in_ready  = !hold_full_reg;
  assign bus.ser_valid = (state_reg == ST_SHIFT);
  assign bus.ser_out   = (state_reg == ST_SHIFT) ? out_bit : 1'b0;
  assign bus.busy      = (state_reg == ST_SHIFT) || hold_full_reg;
  assign bus.word_cnt  = word_cnt_reg;

  // Next-state logic: load, shift, refill from hold or go idle.
  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    bit_cnt_next   = bit_cnt_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    word_cnt_next  = word_cnt_reg;

    if (state_reg == ST_IDLE) begin
      // Empty shifter: a new word goes straight in, first bit next cycle.
      if (xfer) begin
        shreg_next   = bus.in_data;
        bit_cnt_next = CNT_FULL;
        state_next   = ST_SHIFT;
      end
    end else if (last_bit) begin
      // Final bit consumed: refill without a bubble if anything is waiting.
      word_cnt_next = word_cnt_reg + 16'd1;
      if (hold_full_reg) begin
        shreg_next     = hold_reg;
        bit_cnt_next   = CNT_FULL;
        hold_full_next = 1'b0;
      end else if (xfer) begin
        shreg_next   = bus.in_data;
        bit_cnt_next = CNT_FULL;
      end else begin
        shreg_next   = '0;
        bit_cnt_next = '0;
        state_next   = ST_IDLE;
      end
    end else begin
      // Mid-word: shift when consumed, park any accepted word in the hold.
      if (bus.ser_en) begin
        shreg_next   = shreg_shifted;
        bit_cnt_next = bit_cnt_reg - CNT_ONE;
      end
      if (xfer) begin
        hold_next      = bus.in_data;
        hold_full_next = 1'b1;
      end
    end
  end

  // State registers; reset drops any partial or held word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      word_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      word_cnt_reg  <= word_cnt_next;
    end
  end

endmodule
